// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width never collapses to zero bits, even for a single chunk.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module chunk_add #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic w_c;

    always_comb begin
        w_c = ci;
        s   = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per cycle, LSB chunk first,
// with valid/ready handshakes on both sides.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_done_hs;
    logic              w_last;
    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic [CHUNK-1:0]  w_s;
    logic              w_co;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_done_hs = out_ready && (r_state == DONE);
    assign w_last    = (r_cnt == LAST);
    assign w_base    = 32'(r_cnt) * 32'(CHUNK);
    assign w_a_slice = r_a[w_base +: CHUNK];
    assign w_b_slice = r_b[w_base +: CHUNK];

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (w_done_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-chunk accumulation and final flag latch.
    // Subtraction is folded into A + ~B + !borrow at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum[w_base +: CHUNK] <= w_s;
            r_carry                <= w_co;
            r_cnt                  <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[CHUNK-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed scoreboard bench for chunked_adder: a 16/4 instance and a 4/4 instance.
module tb_chunked_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic        ordy;
    logic        sel;
    logic [15:0] ta;
    logic [15:0] tb;
    logic        tcin;
    logic        tsub;

    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] sum16;
    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [3:0]  sum4;

    logic        m_in_ready, m_out_valid, m_cout, m_ovf;
    logic [15:0] m_sum;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv & ~sel),
        .in_ready  (in_ready16),
        .a         (ta),
        .b         (tb),
        .cin       (tcin),
        .sub       (tsub),
        .out_valid (out_valid16),
        .out_ready (ordy & ~sel),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    chunked_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv & sel),
        .in_ready  (in_ready4),
        .a         (ta[3:0]),
        .b         (tb[3:0]),
        .cin       (tcin),
        .sub       (tsub),
        .out_valid (out_valid4),
        .out_ready (ordy & sel),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    assign m_in_ready  = sel ? in_ready4  : in_ready16;
    assign m_out_valid = sel ? out_valid4 : out_valid16;
    assign m_sum       = sel ? {12'd0, sum4} : sum16;
    assign m_cout      = sel ? cout4 : cout16;
    assign m_ovf       = sel ? ovf4  : ovf16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference from integer arithmetic: unsigned for sum/cout, signed for ovf.
    function automatic exp_t model(input int w, input longint ua, input longint ub,
                                   input bit c, input bit s);
        exp_t   e;
        longint mask, u, sa, sb, sr;
        mask = (64'sd1 <<< w) - 1;
        sa   = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
        sb   = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
        if (!s) begin
            u      = ua + ub + longint'(c);
            e.cout = ((u >>> w) & 1) != 0;
            sr     = sa + sb + longint'(c);
        end else begin
            u      = ua - ub - longint'(c);
            e.cout = (ua >= ub + longint'(c));
            sr     = sa - sb - longint'(c);
        end
        e.sum = 16'(u & mask);
        e.ovf = (sr > (64'sd1 <<< (w - 1)) - 1) || (sr < -(64'sd1 <<< (w - 1)));
        return e;
    endfunction

    // Accept one operand pair, wait for the result, check latency and value, handshake.
    task automatic do_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                         input bit c, input bit s);
        int   n;
        exp_t e;
        n = 0;
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 32'(m_in_ready), 32'd1);
        iv = 1'b1; ta = oa; tb = ob; tcin = c; tsub = s;
        q.push_back(model(sel ? 4 : 16, longint'(oa), longint'(ob), c, s));
        @(posedge clk);
        #1;
        iv = 1'b0; ta = 16'($urandom); tb = 16'($urandom); tcin = ~c; tsub = ~s;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!m_out_valid && n < 20);
        chk({tag, "_latency"}, 32'(n), sel ? 32'd1 : 32'd4);
        e = q.pop_front();
        chk({tag, "_sum"},  32'(m_sum),  32'(e.sum));
        chk({tag, "_cout"}, 32'(m_cout), 32'(e.cout));
        chk({tag, "_ovf"},  32'(m_ovf),  32'(e.ovf));
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, m_in_ready, m_out_valid}, 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        bit   seen;
        exp_t e;
        logic [15:0] hold_sum;

        rst = 1'b1; iv = 1'b0; ordy = 1'b0; sel = 1'b0;
        ta = '0; tb = '0; tcin = 1'b0; tsub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst16_outs", {12'd0, in_ready16, out_valid16, cout16, ovf16, sum16}, {12'd0, 4'b1000, 16'h0});
        chk("rst4_outs",  {24'd0, in_ready4, out_valid4, cout4, ovf4, sum4},      {24'd0, 4'b1000, 4'h0});
        rst = 1'b0;
        @(negedge clk);

        // Abort an operation with a reset two edges after accept
        iv = 1'b1; ta = 16'h1234; tb = 16'h1111; tcin = 1'b0; tsub = 1'b0;
        @(posedge clk);
        #1 iv = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rst", {15'd0, out_valid16, sum16}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(in_ready16), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid16) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        do_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0);

        // 16-bit arithmetic corners
        do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0);
        do_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b0 | 1'b1);
        do_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1);
        do_op("sub_borin", 16'h0010, 16'h0003, 1'b1, 1'b1);
        do_op("add_neg",   16'h8000, 16'h8000, 1'b1, 1'b0);

        // Backpressure: hold the result for 10 cycles while in_valid pulses
        iv = 1'b1; ta = 16'hA5A5; tb = 16'h0F0F; tcin = 1'b0; tsub = 1'b0;
        q.push_back(model(16, 64'hA5A5, 64'h0F0F, 1'b0, 1'b0));
        @(posedge clk);
        #1 iv = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid16 && n < 20);
        chk("bp_valid", 32'(out_valid16), 32'd1);
        e = q.pop_front();
        hold_sum = sum16;
        chk("bp_sum", 32'(sum16), 32'(e.sum));
        for (int i = 0; i < 10; i++) begin
            iv = i[0]; ta = 16'($urandom); tb = 16'($urandom);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_hold", {12'd0, out_valid16, in_ready16, cout16, ovf16, sum16},
                {12'd0, 1'b1, 1'b0, e.cout, e.ovf, hold_sum});
        end
        iv = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        @(negedge clk);
        chk("bp_release", {30'd0, in_ready16, out_valid16}, 32'b10);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid16) seen = 1'b1;
        end
        chk("bp_pulses_ignored", 32'(seen), 32'd0);

        // Single-chunk instance behaves like the combinational 4-bit adder
        sel = 1'b1;
        @(negedge clk);
        do_op("w4_0_0",   16'd0,  16'd0,  1'b0, 1'b0);
        do_op("w4_1_1",   16'd1,  16'd1,  1'b0, 1'b0);
        do_op("w4_10_5",  16'd10, 16'd5,  1'b0, 1'b0);
        do_op("w4_15_15", 16'd15, 16'd15, 1'b0, 1'b0);
        do_op("w4_sub",   16'd3,  16'd9,  1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parameterised multi-cycle adder/subtractor. It is the successor to the 4-bit combinational parallel adder and adds WIDTH-bit operands CHUNK bits per clock cycle using a single CHUNK-bit adder slice. It supports add and subtract modes, carry/borrow-in, carry-out and signed overflow. Operands enter and results leave through valid/ready handshakes, so it drops into streaming datapaths where area matters more than throughput.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived; number of compute cycles (localparam, not overridable)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0 = A+B+cin, 1 = A-B-cin
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result, modulo 2^WIDTH
cout  out  1  add: carry-out; sub: 1 = no borrow, 0 = borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE and the chunk counter clears.
  - Outputs: out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from the first edge after rst deasserts.
  - Reset mid-RUN or mid-DONE aborts the operation; the result is never presented.
- States:
  - IDLE -> RUN: on in_valid && in_ready.
  - RUN -> RUN: while counter < NCHUNK-1.
  - RUN -> DONE: on the edge that processes chunk NCHUNK-1.
  - DONE -> IDLE: on out_valid && out_ready.
- in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE).
- Accept edge latches:
  - a_r = a
  - b_r = sub ? ~b : b
  - carry = cin ^ sub
  - counter = 0
  - in_valid without in_ready is ignored; the upstream side holds its data.
- Each RUN edge:
  - {carry, sum[k*CHUNK +: CHUNK]} = a_r[k*CHUNK +: CHUNK] + b_r[k*CHUNK +: CHUNK] + carry, with k = counter.
  - Counter increments.
- Processing is LSB chunk first. Sum bits not yet written hold stale values and are not visible, because out_valid=0 until DONE.
- Latency: out_valid rises NCHUNK edges after the accept edge. Throughput is one operation per NCHUNK+2 cycles at most; there is no overlap, since in_ready is low in RUN and DONE.
- Entering DONE:
  - cout = final carry.
  - ovf = (a_r[MSB]==b_r[MSB]) && (sum[MSB]!=a_r[MSB]).
- DONE with out_ready=0: sum, cout and ovf hold stable indefinitely.
- Handshake edge in DONE: return to IDLE. A new operand is accepted no earlier than the following edge.
- CHUNK==WIDTH (NCHUNK=1): one RUN cycle. Result equals the combinational parallel adder's.
- Input changes on a/b/cin/sub outside an accept edge have no effect.

Decomposition:
- Shared package adder_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit)
  - function clog2 for the counter width, max(1, clog2(NCHUNK))
- Sub-module chunk_add: combinational CHUNK-bit ripple adder slice with ports (a, b, ci) -> (s, co), instantiated once. The top level owns the FSM, counter and operand/result registers.

Test Plan:
- Reset mid-RUN (accept 0x1234+0x1111, assert rst two cycles later) -> out_valid stays 0, sum=0, in_ready=1 after release. Next op 0x0001+0x0001 -> 0x0002.
- WIDTH=16/CHUNK=4, add 0xFFFF+0x0001 cin=0 -> sum=0x0000, cout=1, ovf=0. out_valid exactly 4 edges after accept.
- Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Add 0x1234+0x4321 cin=1 -> 0x5556, cout=0, ovf=0.
- Sub 0x0005-0x0007 cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses are ignored. Release -> one handshake, back to IDLE.
- WIDTH=4/CHUNK=4 regression: 0+0, 1+1, 10+5, 15+15 -> sum 0000/0010/1111/1110 and cout 0/0/0/1, each after 1 compute cycle.
